ball_renderer: RTL and testbench

//  Parametrised, pipelined successor to the per-frame ball overlay. Draws up to MAX_BALLS round balls,

---
 rtl/juggle_pkg.sv | 20 ++
 rtl/ball_hit_unit.sv | 46 ++++
 rtl/ball_renderer.sv | 138 +++++++++++++
 tb/tb_ball_renderer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/juggle_pkg.sv
// Shared types and colour constants for the juggling overlay renderer.
package juggle_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int   RENDER_LATENCY = 3;
   localparam rgb_t HAND_COLOR     = 24'h00FF00;

   // Kept clear of HAND_COLOR so a ball is always distinguishable from a hand.
   localparam rgb_t BALL_PALETTE [0:14] = '{
      24'hFF0000, 24'h0000FF, 24'hFFFF00, 24'hFF00FF, 24'h00FFFF,
      24'hFF8000, 24'h8000FF, 24'hFFFFFF, 24'h808080, 24'h800000,
      24'h000080, 24'h808000, 24'h008080, 24'hFF80C0, 24'h80FF80
   };

endpackage

// File: rtl/ball_hit_unit.sv
// One ball channel: S1 signed offsets from the ball centre, S2 squared distance
// compared against the radius, giving a registered hit flag.
module ball_hit_unit #(
   parameter int BALL_RADIUS = 8,
   parameter int HCOUNT_W    = 11,
   parameter int VCOUNT_W    = 10
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                en,
   input  logic [HCOUNT_W-1:0] hcount,
   input  logic [VCOUNT_W-1:0] vcount,
   input  logic [HCOUNT_W-1:0] ball_x,
   input  logic [VCOUNT_W-1:0] ball_y,
   output logic                hit
);

   localparam int DW   = HCOUNT_W + 1;
   localparam int SQ_W = 2 * DW + 1;
   localparam logic [SQ_W-1:0] R_SQ = SQ_W'(BALL_RADIUS * BALL_RADIUS);

   logic signed [DW-1:0]   dx, dy;
   logic                   en_s1;
   logic signed [2*DW-1:0] dx_sq, dy_sq;
   logic [SQ_W-1:0]        sq;

   // Squares of a DW-bit signed value are never negative, so the sign bit is always 0.
   assign dx_sq = dx * dx;
   assign dy_sq = dy * dy;
   assign sq    = SQ_W'($unsigned(dx_sq)) + SQ_W'($unsigned(dy_sq));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         dx    <= '0;
         dy    <= '0;
         en_s1 <= 1'b0;
         hit   <= 1'b0;
      end else begin
         dx    <= $signed(DW'(hcount)) - $signed(DW'(ball_x));
         dy    <= $signed(DW'(vcount)) - $signed(DW'(ball_y));
         en_s1 <= en;
         hit   <= en_s1 && (sq <= R_SQ);
      end
   end

endmodule

// File: rtl/ball_renderer.sv
// Ball/hand overlay: double-buffered trajectory banks swapped at frame start,
// per-ball hit units, hand boxes, and a lowest-index-wins colour select.
module ball_renderer
   import juggle_pkg::*;
#(
   parameter int MAX_BALLS   = 7,
   parameter int BALL_RADIUS = 8,
   parameter int HAND_HALF   = 12,
   parameter int HCOUNT_W    = 11,
   parameter int VCOUNT_W    = 10,
   localparam int NB_W       = $clog2(MAX_BALLS + 1)
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic [NB_W-1:0]                    num_balls,
   input  logic [MAX_BALLS-1:0][HCOUNT_W-1:0] traj_x_in,
   input  logic [MAX_BALLS-1:0][VCOUNT_W-1:0] traj_y_in,
   input  logic                               traj_valid,
   input  logic [1:0][HCOUNT_W-1:0]           hand_x_in,
   input  logic [1:0][VCOUNT_W-1:0]           hand_y_in,
   input  logic                               new_frame_in,
   input  logic [HCOUNT_W-1:0]                hcount_in,
   input  logic [VCOUNT_W-1:0]                vcount_in,
   output logic [7:0]                         red_out,
   output logic [7:0]                         green_out,
   output logic [7:0]                         blue_out
);

   localparam int DW = HCOUNT_W + 1;
   localparam logic signed [DW-1:0] HH = DW'(HAND_HALF);

   logic [MAX_BALLS-1:0][HCOUNT_W-1:0] pend_x, act_x;
   logic [MAX_BALLS-1:0][VCOUNT_W-1:0] pend_y, act_y;
   logic [1:0][HCOUNT_W-1:0]           pend_hx, act_hx;
   logic [1:0][VCOUNT_W-1:0]           pend_hy, act_hy;
   logic [NB_W-1:0]                    pend_nb, act_nb, nb_clamped;
   logic                               pend_full, act_ok;

   logic [MAX_BALLS-1:0] ball_en, hit_s2;
   logic [1:0]           hand_box, hand_s1, hand_s2;
   rgb_t                 pix_c, pix_q;

   assign nb_clamped = (num_balls > NB_W'(MAX_BALLS)) ? NB_W'(MAX_BALLS) : num_balls;

   // A same-cycle strobe and frame start promote the old PENDING and keep the new one queued.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pend_x    <= '0;
         pend_y    <= '0;
         pend_hx   <= '0;
         pend_hy   <= '0;
         pend_nb   <= '0;
         pend_full <= 1'b0;
         act_x     <= '0;
         act_y     <= '0;
         act_hx    <= '0;
         act_hy    <= '0;
         act_nb    <= '0;
         act_ok    <= 1'b0;
      end else begin
         if (traj_valid) begin
            pend_x  <= traj_x_in;
            pend_y  <= traj_y_in;
            pend_hx <= hand_x_in;
            pend_hy <= hand_y_in;
            pend_nb <= nb_clamped;
         end
         if (new_frame_in && pend_full) begin
            act_x  <= pend_x;
            act_y  <= pend_y;
            act_hx <= pend_hx;
            act_hy <= pend_hy;
            act_nb <= pend_nb;
            act_ok <= 1'b1;
         end
         if (traj_valid)
            pend_full <= 1'b1;
         else if (new_frame_in)
            pend_full <= 1'b0;
      end
   end

   for (genvar i = 0; i < MAX_BALLS; i++) begin : g_ball
      assign ball_en[i] = (NB_W'(i) < act_nb);

      ball_hit_unit #(
         .BALL_RADIUS (BALL_RADIUS),
         .HCOUNT_W    (HCOUNT_W),
         .VCOUNT_W    (VCOUNT_W)
      ) u_hit (
         .clk_in (clk_in),
         .rst_in (rst_in),
         .en     (ball_en[i]),
         .hcount (hcount_in),
         .vcount (vcount_in),
         .ball_x (act_x[i]),
         .ball_y (act_y[i]),
         .hit    (hit_s2[i])
      );
   end

   for (genvar j = 0; j < 2; j++) begin : g_hand
      logic signed [DW-1:0] hdx, hdy;
      assign hdx         = $signed(DW'(hcount_in)) - $signed(DW'(act_hx[j]));
      assign hdy         = $signed(DW'(vcount_in)) - $signed(DW'(act_hy[j]));
      assign hand_box[j] = (hdx <= HH) && (hdx >= -HH) && (hdy <= HH) && (hdy >= -HH);
   end

   // Walk from the top index down so the lowest-index hit is the last to write.
   always_comb begin
      pix_c = '0;
      if (hand_s2 != 2'b00)
         pix_c = HAND_COLOR;
      for (int i = MAX_BALLS - 1; i >= 0; i--) begin
         if (hit_s2[i])
            pix_c = BALL_PALETTE[i];
      end
      if (!act_ok)
         pix_c = '0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hand_s1 <= '0;
         hand_s2 <= '0;
         pix_q   <= '0;
      end else begin
         hand_s1 <= hand_box;
         hand_s2 <= hand_s1;
         pix_q   <= pix_c;
      end
   end

   assign red_out   = pix_q.r;
   assign green_out = pix_q.g;
   assign blue_out  = pix_q.b;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: each probe drives one pixel for one cycle,
// parks the scan elsewhere, and checks the colour exactly three edges later.
module tb_ball_renderer;

   localparam logic [23:0] PAL0  = 24'hFF0000;
   localparam logic [23:0] PAL1  = 24'h0000FF;
   localparam logic [23:0] PAL6  = 24'h8000FF;
   localparam logic [23:0] HAND  = 24'h00FF00;
   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [10:0] PARK_H = 11'd1500;
   localparam logic [9:0]  PARK_V = 10'd900;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic [2:0]        num_balls;
   logic [6:0][10:0]  traj_x;
   logic [6:0][9:0]   traj_y;
   logic              traj_valid;
   logic [1:0][10:0]  hand_x;
   logic [1:0][9:0]   hand_y;
   logic              new_frame_in;
   logic [10:0]       hcount_in;
   logic [9:0]        vcount_in;
   logic [7:0]        red_out, green_out, blue_out;

   int n_checks = 0;
   int n_pass   = 0;

   ball_renderer dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .num_balls    (num_balls),
      .traj_x_in    (traj_x),
      .traj_y_in    (traj_y),
      .traj_valid   (traj_valid),
      .hand_x_in    (hand_x),
      .hand_y_in    (hand_y),
      .new_frame_in (new_frame_in),
      .hcount_in    (hcount_in),
      .vcount_in    (vcount_in),
      .red_out      (red_out),
      .green_out    (green_out),
      .blue_out     (blue_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic probe(input int h, input int v, input logic [23:0] exp, input string tag);
      @(negedge clk_in);
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      @(negedge clk_in);
      hcount_in = PARK_H;
      vcount_in = PARK_V;
      @(posedge clk_in);
      @(posedge clk_in);
      #1;
      check(tag, {red_out, green_out, blue_out}, exp);
   endtask

   task automatic strobe();
      @(negedge clk_in);
      traj_valid = 1'b1;
      @(negedge clk_in);
      traj_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge clk_in);
      new_frame_in = 1'b1;
      @(negedge clk_in);
      new_frame_in = 1'b0;
   endtask

   task automatic park_all();
      for (int i = 0; i < 7; i++) begin
         traj_x[i] = 11'(300 + 40 * i);
         traj_y[i] = 10'd500;
      end
      hand_x[0] = 11'd1000; hand_y[0] = 10'd100;
      hand_x[1] = 11'd800;  hand_y[1] = 10'd700;
   endtask

   initial begin
      rst_in       = 1'b1;
      traj_valid   = 1'b0;
      new_frame_in = 1'b0;
      num_balls    = 3'd0;
      hcount_in    = PARK_H;
      vcount_in    = PARK_V;
      park_all();
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      // Nothing swapped in yet: black everywhere, even over the reset-zero hand position.
      probe(0, 0, BLACK, "t1_origin");
      probe(5, 5, BLACK, "t1_near_origin");
      probe(100, 100, BLACK, "t1_mid");
      probe(2047, 1023, BLACK, "t1_corner");
      pulse_frame();
      probe(0, 0, BLACK, "t1_frame_no_pending");

      // Single ball radius boundary.
      num_balls = 3'd1;
      traj_x[0] = 11'd100; traj_y[0] = 10'd100;
      strobe();
      pulse_frame();
      probe(100, 108, PAL0, "t2_edge_dy8");
      probe(100, 109, BLACK, "t2_outside_dy9");
      probe(106, 106, BLACK, "t2_sq72");
      probe(105, 105, PAL0, "t2_sq50");
      probe(92, 100, PAL0, "t2_edge_dx_neg8");

      // Overlapping balls and a hand: lowest index wins, balls over hands.
      park_all();
      num_balls = 3'd3;
      traj_x[1] = 11'd200; traj_y[1] = 10'd50;
      traj_x[2] = 11'd200; traj_y[2] = 10'd50;
      hand_x[0] = 11'd200; hand_y[0] = 10'd50;
      strobe();
      pulse_frame();
      probe(200, 50, PAL1, "t3_ball1_over_ball2_hand");
      probe(212, 50, HAND, "t3_hand_edge_x");
      probe(213, 50, BLACK, "t3_hand_outside");
      probe(200, 62, HAND, "t3_hand_edge_y");
      probe(300, 500, PAL0, "t3_ball0");

      // Double buffering.
      park_all();
      num_balls = 3'd1;
      traj_x[0] = 11'd100; traj_y[0] = 10'd100;
      strobe();
      pulse_frame();
      traj_x[0] = 11'd400; traj_y[0] = 10'd300;
      strobe();
      probe(100, 100, PAL0, "t4_old_still_drawn");
      probe(400, 300, BLACK, "t4_new_not_yet");
      pulse_frame();
      probe(400, 300, PAL0, "t4_new_after_frame");
      probe(100, 100, BLACK, "t4_old_gone");
      traj_x[0] = 11'd500; traj_y[0] = 10'd400;
      strobe();
      @(negedge clk_in);
      traj_x[0] = 11'd700; traj_y[0] = 10'd200;
      traj_valid   = 1'b1;
      new_frame_in = 1'b1;
      @(negedge clk_in);
      traj_valid   = 1'b0;
      new_frame_in = 1'b0;
      probe(500, 400, PAL0, "t4_same_cycle_prev_pending");
      probe(700, 200, BLACK, "t4_same_cycle_new_held");
      pulse_frame();
      probe(700, 200, PAL0, "t4_held_after_frame");
      probe(500, 400, BLACK, "t4_prev_gone");
      pulse_frame();
      probe(700, 200, PAL0, "t4_frame_without_pending");

      // Ball at the origin is clipped, no aliasing at the far corner.
      park_all();
      num_balls = 3'd6;
      traj_x[6] = 11'd0; traj_y[6] = 10'd0;
      strobe();
      pulse_frame();
      probe(0, 0, BLACK, "t5_ball6_disabled");
      num_balls = 3'd7;
      strobe();
      pulse_frame();
      probe(0, 0, PAL6, "t5_ball6_origin");
      probe(0, 8, PAL6, "t5_ball6_edge");
      probe(3, 3, PAL6, "t5_ball6_inside");
      probe(2047, 1023, BLACK, "t5_far_corner");
      probe(2047, 0, BLACK, "t5_far_x");

      // Asynchronous reset between clock edges.
      @(negedge clk_in);
      hcount_in = 11'd0;
      vcount_in = 10'd0;
      repeat (4) @(posedge clk_in);
      #1;
      check("t6_before_reset", {red_out, green_out, blue_out}, PAL6);
      #2;
      rst_in = 1'b1;
      #1;
      check("t6_async_clear", {red_out, green_out, blue_out}, BLACK);
      @(negedge clk_in);
      #2;
      rst_in = 1'b0;
      probe(0, 0, BLACK, "t6_after_reset");
      strobe();
      probe(0, 0, BLACK, "t6_strobe_only");
      pulse_frame();
      probe(0, 0, PAL6, "t6_after_swap");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
